// File: rtl/mux_nto1_scan_pkg.sv
// mux_scan_pkg: shared FSM state and mode encodings for the scanning channel mux
package mux_scan_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO = 1'b1;
endpackage

// File: rtl/mux_nto1_scan_if.sv
// mux_nto1_scan_if: valid/ready sample stream carrying the data word and its source channel
interface mux_nto1_scan_if #(
    parameter int WIDTH = 8,
    parameter int NCH = 8
);
    localparam int SELW = $clog2(NCH);
    logic [WIDTH-1:0] out_data;
    logic [SELW-1:0] out_sel;
    logic out_valid;
    logic out_ready;
    modport master(output out_data, out_sel, out_valid, input out_ready);
    modport slave(input out_data, out_sel, out_valid, output out_ready);
endinterface

// File: rtl/mux_nto1_scan_mux.sv
// mux_nto1: combinational WIDTH-bit NCH:1 select; indices past the last channel give zero
module mux_nto1 #(
    parameter int WIDTH = 8,
    parameter int NCH = 8,
    parameter int SELW = $clog2(NCH)
) (
    input  logic [NCH*WIDTH-1:0] ch_in,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     y
);
    always_comb begin
        y = '0;
        for (int k = 0; k < NCH; k++) y = (sel == SELW'(k)) ? ch_in[k*WIDTH +: WIDTH] : y;
    end
endmodule

// File: rtl/mux_nto1_scan.sv
// mux_nto1_scan: registered N:1 channel mux with manual or round-robin select over a valid/ready output
module mux_nto1_scan
    import mux_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH = 8,
    parameter int SELW = $clog2(NCH),
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] ch_in,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel_in,
    input  logic                 sel_load,
    output logic                 sel_err,
    mux_nto1_scan_if.master      o
);
    localparam int DCW = $clog2(DWELL + 1);
    state_t state, nxt;
    logic [SELW-1:0] cur_sel;
    logic [DCW-1:0] dwell_cnt;
    logic [WIDTH-1:0] mux_y;
    logic mode_q, accept, load, sel_ok, last;

    mux_nto1 #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) u_mux (.ch_in(ch_in), .sel(cur_sel), .y(mux_y));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state == IDLE ? (en ? RUN : IDLE)
            : state == RUN ? (en ? RUN : (o.out_valid & ~o.out_ready) ? DRAIN : IDLE)
            : (accept ? IDLE : DRAIN);
    end

    always_comb begin
        accept = o.out_valid & o.out_ready;
        load = (state == RUN) & (~o.out_valid | o.out_ready);
        sel_ok = sel_load & (int'(sel_in) < NCH);
        last = dwell_cnt == DCW'(DWELL - 1);
    end

    // explicit loads beat the mode-edge clear, which beats auto-advance
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cur_sel <= '0;
            dwell_cnt <= '0;
            mode_q <= MODE_MANUAL;
            sel_err <= 1'b0;
        end else begin
            mode_q <= mode;
            sel_err <= sel_load & (int'(sel_in) >= NCH);
            if (sel_ok) begin
                cur_sel <= sel_in;
                dwell_cnt <= '0;
            end else if (mode != mode_q || mode == MODE_MANUAL) dwell_cnt <= '0;
            else if (accept) begin
                dwell_cnt <= last ? '0 : dwell_cnt + 1'b1;
                if (last) cur_sel <= (cur_sel == SELW'(NCH - 1)) ? '0 : cur_sel + 1'b1;
            end
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            o.out_data <= '0;
            o.out_sel <= '0;
            o.out_valid <= 1'b0;
        end else begin
            if (load) begin
                o.out_data <= mux_y;
                o.out_sel <= cur_sel;
            end
            o.out_valid <= load | (o.out_valid & ~o.out_ready);
        end
endmodule

// File: tb/tb_mux_nto1_scan.sv
// tb_mux_nto1_scan: two instances (8 ch / dwell 2, 6 ch / dwell 3) checked against a transfer-level model
module tb_mux_nto1_scan;
    logic clk = 0, rst_n = 0, en = 0, mode = 0, sel_load = 0, ready = 0;
    logic [2:0] sel_in = 0;
    logic [63:0] chv = 0;
    logic err_a, err_b;
    int checks = 0, errors = 0;
    int nch[2] = '{8, 6};
    int dwl[2] = '{2, 3};
    int m_st[2], m_cur[2], m_dw[2], m_od[2], m_os[2], m_ov[2], m_err[2], m_mq[2];
    logic [12:0] ob[2];

    always #5 clk = ~clk;

    mux_nto1_scan_if #(.WIDTH(8), .NCH(8)) ia ();
    mux_nto1_scan_if #(.WIDTH(8), .NCH(6)) ib ();
    assign ia.out_ready = ready;
    assign ib.out_ready = ready;

    mux_nto1_scan #(.WIDTH(8), .NCH(8), .DWELL(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .ch_in(chv), .en(en), .mode(mode),
        .sel_in(sel_in), .sel_load(sel_load), .sel_err(err_a), .o(ia));
    mux_nto1_scan #(.WIDTH(8), .NCH(6), .DWELL(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .ch_in(chv[47:0]), .en(en), .mode(mode),
        .sel_in(sel_in), .sel_load(sel_load), .sel_err(err_b), .o(ib));

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_cur[i] = 0; m_dw[i] = 0; m_od[i] = 0;
            m_os[i] = 0; m_ov[i] = 0; m_err[i] = 0; m_mq[i] = 0;
        end
    endtask

    // one clock of the transfer-level rules: 0=idle 1=run 2=drain
    task automatic model_step();
        int acc, ld, old;
        for (int i = 0; i < 2; i++) begin
            acc = (m_ov[i] == 1 && ready) ? 1 : 0;
            ld = (m_st[i] == 1 && (m_ov[i] == 0 || ready)) ? 1 : 0;
            old = m_cur[i];
            if (m_st[i] == 0) m_st[i] = en ? 1 : 0;
            else if (m_st[i] == 1) m_st[i] = en ? 1 : (m_ov[i] == 1 && !ready) ? 2 : 0;
            else if (acc == 1) m_st[i] = 0;
            m_err[i] = (sel_load && int'(sel_in) >= nch[i]) ? 1 : 0;
            if (sel_load && int'(sel_in) < nch[i]) begin
                m_cur[i] = int'(sel_in);
                m_dw[i] = 0;
            end else if (int'(mode) != m_mq[i] || !mode) m_dw[i] = 0;
            else if (acc == 1) begin
                m_dw[i] = m_dw[i] + 1;
                if (m_dw[i] == dwl[i]) begin
                    m_dw[i] = 0;
                    m_cur[i] = (m_cur[i] + 1) % nch[i];
                end
            end
            if (ld == 1) begin
                m_od[i] = int'(chv[old*8 +: 8]);
                m_os[i] = old;
                m_ov[i] = 1;
            end else if (acc == 1) m_ov[i] = 0;
            m_mq[i] = int'(mode);
        end
    endtask

    function automatic logic [12:0] exp_of(int i);
        logic [31:0] e, v, s, d;
        e = m_err[i]; v = m_ov[i]; s = m_os[i]; d = m_od[i];
        return {e[0], v[0], s[2:0], d[7:0]};
    endfunction

    task automatic sample();
        ob[0] = {err_a, ia.out_valid, ia.out_sel, ia.out_data};
        ob[1] = {err_b, ib.out_valid, ib.out_sel, ib.out_data};
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        sample();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ob[i] !== 13'd0) begin
                errors++;
                $display("FAIL reset_init[%0d]: got %h expected %h", i, ob[i], 13'd0);
            end
        end
        @(negedge clk) rst_n = 1;
        #4;
        en = 1; ready = 0; chv = {$urandom, $urandom};
        repeat (3) cyc();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ob[i] !== exp_of(i) || ob[i][11] !== 1'b1) begin
                errors++;
                $display("FAIL reset_prerun[%0d]: got %h expected %h", i, ob[i], exp_of(i));
            end
        end
        #3 rst_n = 0;
        #1 sample();
        model_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ob[i] !== 13'd0) begin
                errors++;
                $display("FAIL reset_async[%0d]: got %h expected %h", i, ob[i], 13'd0);
            end
        end
        en = 0;
        @(negedge clk) rst_n = 1;
        #4;
    endtask

    task automatic test_manual();
        for (int k = 0; k < 8; k++) chv[k*8 +: 8] = 8'h10 + 8'(k);
        mode = 0; en = 1; ready = 1; sel_in = 5; sel_load = 1;
        cyc();
        sel_load = 0;
        cyc();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ob[i][11:0] !== {1'b1, 3'd5, 8'h15}) begin
                errors++;
                $display("FAIL manual_first[%0d]: got %h expected %h", i, ob[i][11:0], {1'b1, 3'd5, 8'h15});
            end
        end
        for (int n = 0; n < 8; n++) begin
            if (n >= 4) chv = {$urandom, $urandom};
            cyc();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ob[i] !== exp_of(i) || ob[i][10:8] !== 3'd5) begin
                    errors++;
                    $display("FAIL manual[%0d]: got %h expected %h", i, ob[i], exp_of(i));
                end
            end
        end
    endtask

    task automatic test_auto();
        int prev = -1;
        bit wrap = 0;
        sel_in = 0; sel_load = 1; mode = 1; ready = 1; en = 1;
        cyc();
        sel_load = 0;
        for (int n = 0; n < 40; n++) begin
            chv = {$urandom, $urandom};
            cyc();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ob[i] !== exp_of(i)) begin
                    errors++;
                    $display("FAIL auto[%0d] n=%0d: got %h expected %h", i, n, ob[i], exp_of(i));
                end
            end
            if (ia.out_valid) begin
                if (prev == 7 && ia.out_sel == 3'd0) wrap = 1;
                prev = int'(ia.out_sel);
            end
        end
        checks++;
        if (!wrap) begin
            errors++;
            $display("FAIL auto_wrap: got no 7->0 transition, expected one");
        end
    endtask

    task automatic test_backpressure();
        logic [12:0] held[2];
        ready = 0;
        cyc();
        held = ob;
        for (int n = 0; n < 3; n++) begin
            chv = {$urandom, $urandom};
            cyc();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ob[i] !== exp_of(i) || ob[i][11:0] !== held[i][11:0]) begin
                    errors++;
                    $display("FAIL backpressure_hold[%0d]: got %h expected %h", i, ob[i], held[i]);
                end
            end
        end
        ready = 1;
        for (int n = 0; n < 8; n++) begin
            chv = {$urandom, $urandom};
            cyc();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ob[i] !== exp_of(i)) begin
                    errors++;
                    $display("FAIL backpressure_resume[%0d]: got %h expected %h", i, ob[i], exp_of(i));
                end
            end
        end
    endtask

    task automatic test_coincide();
        bit found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (m_ov[0] == 1 && m_dw[0] == 1 && m_mq[0] == 1) found = 1;
            else cyc();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL coincide_wait: got no advance slot in 20 cycles, expected one");
        end
        sel_in = 3; sel_load = 1;
        cyc();
        sel_load = 0;
        cyc();
        checks++;
        if (ia.out_sel !== 3'd3 || ob[0] !== exp_of(0)) begin
            errors++;
            $display("FAIL coincide_sel: got sel %0d (%h) expected sel 3 (%h)", ia.out_sel, ob[0], exp_of(0));
        end
    endtask

    task automatic test_sel_err();
        logic [2:0] bsel;
        mode = 0;
        repeat (2) cyc();
        bsel = ib.out_sel;
        sel_in = 7; sel_load = 1;
        cyc();
        sel_load = 0;
        checks++;
        if (err_b !== 1'b1 || ib.out_sel !== bsel || ob[1] !== exp_of(1)) begin
            errors++;
            $display("FAIL sel_err_pulse: got err %b sel %0d expected err 1 sel %0d", err_b, ib.out_sel, bsel);
        end
        checks++;
        if (err_a !== 1'b0 || ob[0] !== exp_of(0)) begin
            errors++;
            $display("FAIL sel_err_a: got %h expected %h", ob[0], exp_of(0));
        end
        cyc();
        checks++;
        if (err_b !== 1'b0 || ib.out_sel !== bsel) begin
            errors++;
            $display("FAIL sel_err_clear: got err %b sel %0d expected err 0 sel %0d", err_b, ib.out_sel, bsel);
        end
    endtask

    task automatic test_drain();
        mode = 1; en = 1; ready = 1;
        repeat (3) cyc();
        ready = 0;
        cyc();
        en = 0;
        for (int n = 0; n < 3; n++) begin
            chv = {$urandom, $urandom};
            cyc();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ob[i] !== exp_of(i) || ob[i][11] !== 1'b1) begin
                    errors++;
                    $display("FAIL drain_hold[%0d]: got %h expected %h", i, ob[i], exp_of(i));
                end
            end
        end
        ready = 1;
        for (int n = 0; n < 4; n++) begin
            chv = {$urandom, $urandom};
            cyc();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ob[i] !== exp_of(i) || ob[i][11] !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_idle[%0d]: got %h expected %h", i, ob[i], exp_of(i));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            chv = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 40) == 0) mode = ~mode;
            ready = ($urandom_range(0, 3) != 0);
            sel_in = 3'($urandom_range(0, 7));
            sel_load = (sel_in < 3'd6) && ($urandom_range(0, 9) == 0);
            cyc();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ob[i] !== exp_of(i)) begin
                    errors++;
                    $display("FAIL random[%0d] n=%0d: got %h expected %h", i, n, ob[i], exp_of(i));
                end
            end
        end
        sel_load = 0;
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto();
        test_backpressure();
        test_coincide();
        test_sel_err();
        test_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
